// File: rtl/bdd_vector_scoreboard.sv
// Drives pseudo-random vectors to one learned BDD output-bit circuit and scores it against the golden model.
// Optional: define SCOREBOARD_STOP_ON_ERR_EN to end a run on the first scored mismatch.
module bdd_vector_scoreboard #(
    parameter int          VEC_W     = 1894,
    parameter int          NUM_TESTS = 1000000,
    parameter int          DUT_LAT   = 0,
    parameter logic [63:0] DEF_SEED  = 64'h0000_0000_0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             seed_load,
    input  logic [63:0]      seed_i,
    output logic [VEC_W-1:0] vec_o,
    output logic             vec_valid_o,
    input  logic             dut_bit_i,
    input  logic             gold_bit_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [31:0]      test_cnt,
    output logic [31:0]      err_cnt,
    output logic [31:0]      first_err_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [63:0] RST_SEED   = (DEF_SEED == 64'h0) ? 64'h1 : DEF_SEED;
    localparam logic [31:0] LAST_ISSUE = 32'(NUM_TESTS - 1);
    localparam int          PIPE_W     = (DUT_LAT > 0) ? DUT_LAT : 1;
    localparam logic [31:0] LAST_DRAIN = 32'(PIPE_W - 1);
    localparam logic [31:0] NO_ERR     = 32'hFFFF_FFFF;

    state_t      state_q;
    state_t      state_d;
    logic [63:0] lfsr_q;
    logic [31:0] issue_cnt_q;
    logic [31:0] drain_cnt_q;
    logic        idle_or_done;
    logic        accept_start;
    logic        sc_valid;
    logic        mismatch;
    logic        abort;

    assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
    assign accept_start = idle_or_done && start;
    assign mismatch     = sc_valid && (dut_bit_i != gold_bit_i);

`ifdef SCOREBOARD_STOP_ON_ERR_EN
    assign abort = mismatch;
`else
    assign abort = 1'b0;
`endif

    // Bit k of the vector reads LFSR bit (k + k/64) mod 64, so each 64-bit slice is rotated by one more.
    for (genvar k = 0; k < VEC_W; k++) begin : g_map
        assign vec_o[k] = lfsr_q[(k + k / 64) % 64];
    end

    // Result-valid delay line matching the learned circuit's latency.
    if (DUT_LAT > 0) begin : g_pipe
        logic [PIPE_W-1:0] vld_pipe_q;
        logic [PIPE_W-1:0] vld_pipe_d;

        always_comb begin
            vld_pipe_d    = '0;
            vld_pipe_d[0] = vec_valid_o;
            for (int i = 1; i < PIPE_W; i++) begin
                vld_pipe_d[i] = vld_pipe_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_pipe_q <= '0;
            end else if (abort) begin
                vld_pipe_q <= '0;
            end else begin
                vld_pipe_q <= vld_pipe_d;
            end
        end

        assign sc_valid = vld_pipe_q[PIPE_W-1];
    end else begin : g_nopipe
        assign sc_valid = vec_valid_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = DONE;
                end else if (issue_cnt_q == LAST_ISSUE) begin
                    state_d = (DUT_LAT > 0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (abort || (drain_cnt_q == LAST_DRAIN)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vec_valid_o = (state_q == RUN);
        busy        = (state_q == RUN) || (state_q == DRAIN);
        done        = (state_q == DONE);
        pass        = (state_q == DONE) && (err_cnt == 32'h0);
    end

    // A seed load wins over stepping so a same-cycle start issues the new seed first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= RST_SEED;
        end else if (idle_or_done && seed_load) begin
            lfsr_q <= (seed_i == 64'h0) ? 64'h1 : seed_i;
        end else if ((state_q == RUN) && !abort) begin
            lfsr_q <= {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            if (accept_start) begin
                issue_cnt_q <= '0;
            end else if (state_q == RUN) begin
                issue_cnt_q <= issue_cnt_q + 32'd1;
            end
            drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + 32'd1 : 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            test_cnt      <= '0;
            err_cnt       <= '0;
            first_err_idx <= NO_ERR;
        end else if (accept_start) begin
            test_cnt      <= '0;
            err_cnt       <= '0;
            first_err_idx <= NO_ERR;
        end else if (sc_valid) begin
            test_cnt <= test_cnt + 32'd1;
            if (mismatch) begin
                if (err_cnt != NO_ERR) begin
                    err_cnt <= err_cnt + 32'd1;
                end
                if (first_err_idx == NO_ERR) begin
                    first_err_idx <= test_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_bdd_vector_scoreboard.sv
// Scoreboard bench: a zero-latency instance (16 tests) and a three-cycle-latency instance (8 tests).
module tb_bdd_vector_scoreboard;

    localparam int VEC_W = 200;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic             start0, seed_load0, dbit0, gbit0, vv0, busy0, done0, pass0, inv0;
    logic [63:0]      seed0;
    logic [VEC_W-1:0] vec0;
    logic [31:0]      tc0, ec0, fe0;

    logic             start3, seed_load3, dbit3, gbit3, vv3, busy3, done3, pass3;
    logic [63:0]      seed3;
    logic [VEC_W-1:0] vec3;
    logic [31:0]      tc3, ec3, fe3;

    logic [63:0]      m0, m3;
    logic [VEC_W-1:0] sb0[$];
    logic [VEC_W-1:0] sb3[$];

    always #5 clk = ~clk;

    assign dbit0 = ^vec0[15:0];
    assign gbit0 = inv0 ? ~dbit0 : dbit0;

    bdd_vector_scoreboard #(.VEC_W(VEC_W), .NUM_TESTS(16), .DUT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .seed_load(seed_load0), .seed_i(seed0),
        .vec_o(vec0), .vec_valid_o(vv0), .dut_bit_i(dbit0), .gold_bit_i(gbit0),
        .busy(busy0), .done(done0), .pass(pass0), .test_cnt(tc0), .err_cnt(ec0),
        .first_err_idx(fe0)
    );

    bdd_vector_scoreboard #(.VEC_W(VEC_W), .NUM_TESTS(8), .DUT_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .seed_load(seed_load3), .seed_i(seed3),
        .vec_o(vec3), .vec_valid_o(vv3), .dut_bit_i(dbit3), .gold_bit_i(gbit3),
        .busy(busy3), .done(done3), .pass(pass3), .test_cnt(tc3), .err_cnt(ec3),
        .first_err_idx(fe3)
    );

    function automatic logic [63:0] lfsr_step(input logic [63:0] l);
        return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
    endfunction

    function automatic logic [VEC_W-1:0] vec_map(input logic [63:0] l);
        logic [VEC_W-1:0] v;
        for (int k = 0; k < VEC_W; k++) v[k] = l[(k + k / 64) % 64];
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 8;
        if (tc0 !== 32'd0)           begin errors++; $display("[TB] FAIL reset_test_cnt got=%h want=0", tc0); end
        if (ec0 !== 32'd0)           begin errors++; $display("[TB] FAIL reset_err_cnt got=%h want=0", ec0); end
        if (fe0 !== 32'hFFFF_FFFF)   begin errors++; $display("[TB] FAIL reset_first_err got=%h want=ffffffff", fe0); end
        if (busy0 !== 1'b0)          begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy0); end
        if (done0 !== 1'b0)          begin errors++; $display("[TB] FAIL reset_done got=%b want=0", done0); end
        if (pass0 !== 1'b0)          begin errors++; $display("[TB] FAIL reset_pass got=%b want=0", pass0); end
        if (vv0 !== 1'b0)            begin errors++; $display("[TB] FAIL reset_vec_valid got=%b want=0", vv0); end
        if (vec0 !== vec_map(64'h1)) begin errors++; $display("[TB] FAIL reset_vec got=%h want=%h", vec0, vec_map(64'h1)); end
        rst = 1'b0;
        m0 = 64'h1;
        m3 = 64'h1;
        @(negedge clk);
    endtask

    // One full run of the zero-latency instance; poke fires start/seed_load mid-run, which must be ignored.
    task automatic test_run(input bit inv, input bit do_seed, input logic [63:0] seed, input bit poke);
        int cyc = 0;
        int n_valid = 0;
        logic [VEC_W-1:0] exp_v;
        inv0 = inv;
        if (do_seed) m0 = (seed == 64'h0) ? 64'h1 : seed;
        for (int i = 0; i < 16; i++) begin
            sb0.push_back(vec_map(m0));
            m0 = lfsr_step(m0);
        end
        start0 = 1'b1; seed_load0 = do_seed; seed0 = seed;
        @(negedge clk);
        start0 = 1'b0; seed_load0 = 1'b0;
        while (!done0 && cyc < 40) begin
            if (vv0) begin
                checks++;
                if (sb0.size() == 0) begin
                    errors++; $display("[TB] FAIL run_extra_vector got=%h want=none", vec0);
                end else begin
                    exp_v = sb0.pop_front();
                    if (vec0 !== exp_v) begin errors++; $display("[TB] FAIL run_vec%0d got=%h want=%h", n_valid, vec0, exp_v); end
                end
                if (n_valid == 0 && do_seed && seed == 64'h0) begin
                    checks++;
                    if ({vec0[65], vec0[1], vec0[0]} !== 3'b001)
                        begin errors++; $display("[TB] FAIL zero_seed_bits got=%b want=001", {vec0[65], vec0[1], vec0[0]}); end
                end
                n_valid++;
            end
            if (poke && cyc == 3) begin
                start0 = 1'b1; seed_load0 = 1'b1; seed0 = 64'hDEAD_BEEF;
            end else begin
                start0 = 1'b0; seed_load0 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start0 = 1'b0; seed_load0 = 1'b0;
        checks += 9;
        if (done0 !== 1'b1)    begin errors++; $display("[TB] FAIL run_done got=%b want=1", done0); end
        if (cyc != 16)         begin errors++; $display("[TB] FAIL run_cycles got=%0d want=16", cyc); end
        if (n_valid != 16)     begin errors++; $display("[TB] FAIL run_valid_cycles got=%0d want=16", n_valid); end
        if (sb0.size() != 0)   begin errors++; $display("[TB] FAIL run_missing_vectors got=%0d want=0", sb0.size()); end
        if (tc0 !== 32'd16)    begin errors++; $display("[TB] FAIL run_test_cnt got=%0d want=16", tc0); end
        if (ec0 !== (inv ? 32'd16 : 32'd0))
            begin errors++; $display("[TB] FAIL run_err_cnt got=%0d want=%0d", ec0, inv ? 16 : 0); end
        if (fe0 !== (inv ? 32'd0 : 32'hFFFF_FFFF))
            begin errors++; $display("[TB] FAIL run_first_err got=%h want=%h", fe0, inv ? 32'd0 : 32'hFFFF_FFFF); end
        if (pass0 !== !inv)    begin errors++; $display("[TB] FAIL run_pass got=%b want=%b", pass0, !inv); end
        if (busy0 !== 1'b0)    begin errors++; $display("[TB] FAIL run_busy got=%b want=0", busy0); end
        sb0.delete();
        repeat (2) @(negedge clk);
        checks += 2;
        if (tc0 !== 32'd16)       begin errors++; $display("[TB] FAIL done_hold_cnt got=%0d want=16", tc0); end
        if (vec0 !== vec_map(m0)) begin errors++; $display("[TB] FAIL done_hold_lfsr got=%h want=%h", vec0, vec_map(m0)); end
    endtask

    // Latency-3 instance with a single mismatch on the sixth scored result (index 5).
    task automatic test_latency_inject();
        int cyc = 0;
        int n_valid = 0;
        int n_busy = 0;
        logic [VEC_W-1:0] exp_v;
`ifdef SCOREBOARD_STOP_ON_ERR_EN
        int exp_busy = 9;
        logic [31:0] exp_tc = 32'd6;
`else
        int exp_busy = 11;
        logic [31:0] exp_tc = 32'd8;
`endif
        for (int i = 0; i < 8; i++) begin
            sb3.push_back(vec_map(m3));
            m3 = lfsr_step(m3);
        end
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        while (!done3 && cyc < 30) begin
            if (busy3) n_busy++;
            if (vv3) begin
                checks++;
                if (sb3.size() == 0) begin
                    errors++; $display("[TB] FAIL lat_extra_vector got=%h want=none", vec3);
                end else begin
                    exp_v = sb3.pop_front();
                    if (vec3 !== exp_v) begin errors++; $display("[TB] FAIL lat_vec%0d got=%h want=%h", n_valid, vec3, exp_v); end
                end
                n_valid++;
            end
            dbit3 = 1'($urandom);
            gbit3 = dbit3 ^ (cyc == 8);
            @(negedge clk);
            cyc++;
        end
        dbit3 = 1'b0; gbit3 = 1'b0;
        checks += 7;
        if (done3 !== 1'b1)     begin errors++; $display("[TB] FAIL lat_done got=%b want=1", done3); end
        if (n_busy != exp_busy) begin errors++; $display("[TB] FAIL lat_busy_cycles got=%0d want=%0d", n_busy, exp_busy); end
        if (n_valid != 8)       begin errors++; $display("[TB] FAIL lat_valid_cycles got=%0d want=8", n_valid); end
        if (tc3 !== exp_tc)     begin errors++; $display("[TB] FAIL lat_test_cnt got=%0d want=%0d", tc3, exp_tc); end
        if (ec3 !== 32'd1)      begin errors++; $display("[TB] FAIL lat_err_cnt got=%0d want=1", ec3); end
        if (fe3 !== 32'd5)      begin errors++; $display("[TB] FAIL lat_first_err got=%0d want=5", fe3); end
        if (pass3 !== 1'b0)     begin errors++; $display("[TB] FAIL lat_pass got=%b want=0", pass3); end
        sb3.delete();
    endtask

    // Asynchronous reset during the eighth vector, then a clean run from the default seed.
    task automatic test_reset_mid_run();
        logic [VEC_W-1:0] exp_v;
        inv0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sb0.push_back(vec_map(m0));
            m0 = lfsr_step(m0);
        end
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            exp_v = sb0.pop_front();
            checks++;
            if (vv0 !== 1'b1 || vec0 !== exp_v)
                begin errors++; $display("[TB] FAIL mid_vec%0d got=%b/%h want=1/%h", cyc, vv0, vec0, exp_v); end
            @(negedge clk);
        end
        checks++;
        if (tc0 !== 32'd7) begin errors++; $display("[TB] FAIL mid_test_cnt got=%0d want=7", tc0); end
        rst = 1'b1;
        #1;
        checks += 4;
        if (busy0 !== 1'b0 || vv0 !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_state got=%b%b want=00", busy0, vv0); end
        if (tc0 !== 32'd0)                  begin errors++; $display("[TB] FAIL mid_rst_test_cnt got=%0d want=0", tc0); end
        if (fe0 !== 32'hFFFF_FFFF)          begin errors++; $display("[TB] FAIL mid_rst_first_err got=%h want=ffffffff", fe0); end
        if (vec0 !== vec_map(64'h1))        begin errors++; $display("[TB] FAIL mid_rst_lfsr got=%h want=%h", vec0, vec_map(64'h1)); end
        @(negedge clk);
        rst = 1'b0;
        sb0.delete();
        m0 = 64'h1;
        m3 = 64'h1;
        @(negedge clk);
        test_run(1'b0, 1'b0, 64'h0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; inv0 = 1'b0;
        start0 = 1'b0; seed_load0 = 1'b0; seed0 = '0;
        start3 = 1'b0; seed_load3 = 1'b0; seed3 = '0; dbit3 = 1'b0; gbit3 = 1'b0;
        test_reset();
        test_run(1'b0, 1'b0, 64'h0, 1'b0);
        test_run(1'b1, 1'b0, 64'h0, 1'b1);
        test_run(1'b0, 1'b1, 64'h0, 1'b0);
        test_latency_inject();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bdd_vector_scoreboard.md
Name: bdd_vector_scoreboard

Overview:
- Stimulus and scoring end for the learned BDD output-bit circuits (the module_output_bit_* family).
- Generates pseudo-random VEC_W-bit input vectors and drives them to one learned circuit.
- Compares the circuit's output bit against the golden CPU model bit and counts tests and mismatches, which yields the circuit-accuracy figure in hardware.
- Sits in the cluster test harness, one instance per learned output bit.

Parameters:
- VEC_W, 1894: width of the driven input vector.
- NUM_TESTS, 1000000: number of vectors per run; must be ≥1.
- DUT_LAT, 0: cycles from vec_o to a valid dut_bit_i/gold_bit_i; 0 means same cycle.
- DEF_SEED, 64'h0000_0000_0000_0001: LFSR value after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a run; honoured only in IDLE or DONE
- seed_load  in  1  load seed_i into the LFSR; honoured only in IDLE or DONE
- seed_i  in  64  new LFSR seed
- vec_o  out  VEC_W  vector to the learned circuit and the golden model
- vec_valid_o  out  1  vec_o is a scored test this cycle
- dut_bit_i  in  1  learned-circuit output, DUT_LAT cycles after its vector
- gold_bit_i  in  1  golden-model output, same timing as dut_bit_i
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- pass  out  1  done and err_cnt==0
- test_cnt  out  32  results scored so far
- err_cnt  out  32  mismatches so far, saturating at 32'hFFFF_FFFF
- first_err_idx  out  32  index (0-based) of the first mismatch; 32'hFFFF_FFFF if none

Behaviour:
- Reset state: FSM=IDLE, LFSR=DEF_SEED, vec_valid_o=0, busy=0, done=0, pass=0, test_cnt=0, err_cnt=0, first_err_idx=32'hFFFF_FFFF, valid pipeline cleared.
- LFSR: 64-bit Fibonacci LFSR. Feedback = l[63]^l[62]^l[60]^l[59]; each step shifts left and inserts the feedback at bit 0.
- Zero-seed rule: a seed of 0 (via seed_load or DEF_SEED) is replaced by 64'h1.
- Vector mapping: vec_o[k] = lfsr[(k + k/64) mod 64] for every k, using the current LFSR value. The mapping is purely combinational from the LFSR register.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start → RUN:
  - clear test_cnt, err_cnt, first_err_idx and the issue counter;
  - the LFSR keeps its value (seed or continuation).
- Same-cycle seed_load and start: the seed loads first, so the first vector of the run uses seed_i.
- RUN, every cycle:
  - vec_valid_o=1;
  - LFSR steps at the clock edge;
  - issue counter increments.
- Leaving RUN: after the cycle that issues vector NUM_TESTS-1, go to DRAIN if DUT_LAT>0, else to DONE.
- DRAIN: vec_valid_o=0 and the LFSR holds. Exit to DONE when the valid pipeline is empty, exactly DUT_LAT cycles.
- Scoring:
  - vec_valid_o is delayed DUT_LAT stages to form sc_valid.
  - When sc_valid=1, the block samples dut_bit_i and gold_bit_i and increments test_cnt.
  - On inequality it increments err_cnt (saturating).
  - If first_err_idx is still all-ones, it is set to the current test_cnt value (pre-increment).
- Timing example: with DUT_LAT=0, start sampled at edge t gives vectors on cycles t+1..t+NUM_TESTS and done=1 from cycle t+NUM_TESTS+1.
- DONE: counters and the LFSR hold; done=1 until the next accepted start.
- Ignored inputs: start and seed_load during RUN or DRAIN have no effect.
- Reset mid-run: immediate return to the reset state; in-flight results are discarded.

Optional Feature:
- Macro: SCOREBOARD_STOP_ON_ERR_EN.
- Defined: the first scored mismatch forces a transition to DONE on the next edge. The mismatch is counted (err_cnt=1, first_err_idx set). vec_valid_o drops that edge, and results still in flight are discarded. The LFSR holds, so it can be read back for replay.
- Undefined: the run always completes all NUM_TESTS.

Test Plan:
- NUM_TESTS=16, DUT_LAT=0, gold_bit_i tied to dut_bit_i, start pulse → 16 cycles of vec_valid_o, then done=1, pass=1, test_cnt=16, err_cnt=0, first_err_idx=32'hFFFF_FFFF.
- NUM_TESTS=16, gold_bit_i = ~dut_bit_i → err_cnt=16, first_err_idx=0, pass=0.
- seed_load with seed_i=0 → first vec_o equals the mapping of lfsr=64'h1: vec_o[0]=1, vec_o[1]=0 and vec_o[65]=0 (65 maps to lfsr[2]). Next vector has lfsr=64'h2.
- DUT_LAT=3, NUM_TESTS=8, mismatch injected only on sc_valid #5 → busy for 11 cycles, err_cnt=1, first_err_idx=5. With SCOREBOARD_STOP_ON_ERR_EN: done asserts on the edge after that mismatch, test_cnt=6.
- rst asserted during RUN at test 7, then a new start → counters restart at 0; the LFSR restarts from DEF_SEED; start pulses during RUN are ignored.
